l1_neuron_mac: RTL and testbench
================================

Name: l1_neuron_mac

Overview:
- Layer-1 dense-neuron engine for the digit recogniser; sits directly downstream of the 16-bit layer-1 weight ROM (256x16 pROM, bypass read mode, 1-cycle read latency).
- Takes a binarised N_IN-pixel feature vector, streams N_OUT*(N_IN+1) weight words out of the ROM, and accumulates each neuron's dot product plus bias.
- Emits one result per neuron to the layer-2 stage.

Parameters:
- N_IN, 36, pixels per vector; also weights per neuron, excluding bias.
- N_OUT, 4, neurons; ROM holds N_OUT*(N_IN+1) words.
- ACC_W, 24, signed accumulator and result width; must be >= 16+clog2(N_IN+1).
- BASE_ADDR, 0, ROM word address of neuron 0, weight 0.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- start  in  1  one-cycle request; honoured only when busy=0.
- pix  in  N_IN  binary feature vector, captured when start is accepted.
- busy  out  1  high while a vector is in progress.
- rom_ce  out  1  ROM clock enable.
- rom_oce  out  1  ROM output clock enable; held at 1.
- rom_ad  out  8  ROM word address.
- rom_dout  in  16  ROM data, signed two's complement, valid 1 cycle after the address.
- out_valid  out  1  one-cycle strobe, one per neuron.
- out_idx  out  clog2(N_OUT)  neuron index of the current result.
- out_val  out  ACC_W  signed neuron result.
- done  out  1  one-cycle pulse, asserted together with the last out_valid.

Behaviour:
- Reset values: busy=0, rom_ce=0, rom_ad=0, out_valid=0, out_idx=0, out_val=0, done=0. rom_oce is 1 out of reset.
- Accumulator and internal pixel register clear to 0 on reset.
- FSM states: IDLE, STREAM, DRAIN.
  - IDLE -> STREAM on start while busy=0.
  - STREAM -> DRAIN after the last address has been issued.
  - DRAIN -> IDLE after the last result has been emitted.
- start accepted in cycle T:
  - pix is latched.
  - From T+1: busy=1, rom_ce=1.
  - rom_ad = BASE_ADDR + j at cycle T+1+j, for j = 0 .. N_OUT*(N_IN+1)-1, one address per cycle with no gaps.
  - rom_ce drops after the last address.
- Word ordering: j = k*(N_IN+1) + i.
  - For i < N_IN, the word is the weight of pixel i (pix[0] = LSB) for neuron k.
  - For i = N_IN, the word is the bias of neuron k.
- Data return: rom_dout for address j is consumed at cycle T+2+j.
  - Weight word: acc += pix[i] ? sext(rom_dout) : 0.
  - Bias word: result = acc + sext(rom_dout), and acc clears to 0 in the same cycle.
- Output timing: result registered, so out_valid=1 with out_idx=k at cycle T+3+k*(N_IN+1)+N_IN.
  - With defaults: neuron 0 at T+39, neuron 3 at T+150.
  - done=1 in the same cycle as the neuron N_OUT-1 result.
  - busy=0 from the cycle after done; a new start is accepted in that cycle.
- out_val/out_idx hold their last value between strobes. No backpressure: the consumer must accept every strobe.
- start while busy=1 is ignored, and pix is not re-latched.
- Arithmetic is two's-complement wraparound with no saturation; overflow is impossible within the ACC_W constraint.
- rst_n low mid-operation:
  - Aborts the vector at the next edge and returns to IDLE with all reset values.
  - No out_valid or done is issued for the aborted vector.
  - Any ROM read already in flight is discarded.

Optional Feature:
- Macro L1_NEURON_RELU_EN.
- Defined: out_val = (result < 0) ? 0 : result, i.e. ReLU applied in the output register; timing unchanged.
- Undefined: out_val is the raw signed result.

Test Plan:
- ROM model with all weights 0x0001 and all biases 0x0010; pix all ones -> four strobes, out_val=52 each; out_idx 0,1,2,3 at T+39, T+76, T+113, T+150; done at T+150.
- Same ROM, pix=0 -> out_val=16 for every neuron; rom_ad sequence 0..147 on consecutive cycles starting at T+1.
- All weights 0xFFFF, biases 0x0000, pix all ones -> out_val=-36 (0xFFFFDC); with L1_NEURON_RELU_EN -> 0.
- Weights w[k][i]=i+1, bias=0, pix = 36'h000000005 (bits 0, 2 set) -> out_val=4 for every neuron.
- Second start pulses at T+10 and T+150 -> both ignored, exactly 4 strobes; start at T+151 is accepted and rom_ad=0 at T+152.
- rst_n low at T+50 for 1 cycle -> only the neuron 0 strobe at T+39 appears; all outputs at reset values from T+51; a new start after that gives full correct results.

Source files
------------

// File: rtl/l1_neuron_mac.sv
// Layer-1 dense neuron engine: streams weights/biases from the layer-1 ROM and
// emits one dot-product-plus-bias result per neuron. Optional ReLU via L1_NEURON_RELU_EN.
module l1_neuron_mac #(
  parameter int N_IN      = 36,
  parameter int N_OUT     = 4,
  parameter int ACC_W     = 24,
  parameter int BASE_ADDR = 0,
  localparam int IDX_W    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N_IN-1:0]  pix,
  output logic             busy,
  output logic             rom_ce,
  output logic             rom_oce,
  output logic [7:0]       rom_ad,
  input  logic [15:0]      rom_dout,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [ACC_W-1:0] out_val,
  output logic             done
);

  localparam int I_W = $clog2(N_IN + 1);
  localparam logic [I_W-1:0]   LAST_I  = I_W'(N_IN);
  localparam logic [IDX_W-1:0] LAST_K  = IDX_W'(N_OUT - 1);
  localparam logic [7:0]       BASE_AD = 8'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t           state, state_nxt;
  logic [N_IN-1:0]  pix_reg;
  logic [I_W-1:0]   i_cnt, rd_i;
  logic [IDX_W-1:0] k_cnt, rd_k;
  logic             rd_valid;
  logic [ACC_W-1:0] acc;
  logic             last_addr;
  logic [N_IN-1:0]  pix_shift;
  logic             pix_bit;
  logic [ACC_W-1:0] w_ext, sum, res_out;

  assign rom_oce   = 1'b1;
  assign last_addr = (i_cnt == LAST_I) && (k_cnt == LAST_K);
  assign pix_shift = pix_reg >> rd_i;
  assign pix_bit   = pix_shift[0];
  assign w_ext     = {{(ACC_W-16){rom_dout[15]}}, rom_dout};
  assign sum       = acc + w_ext;

`ifdef L1_NEURON_RELU_EN
  assign res_out = sum[ACC_W-1] ? '0 : sum;
`else
  assign res_out = sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)     state_nxt = STREAM;
      STREAM:  if (last_addr) state_nxt = DRAIN;
      DRAIN:   if (done)      state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    rom_ce = (state == STREAM);
  end

  // rd_* tags follow each address by one cycle so they line up with rom_dout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pix_reg   <= '0;
      i_cnt     <= '0;
      k_cnt     <= '0;
      rd_i      <= '0;
      rd_k      <= '0;
      rd_valid  <= 1'b0;
      acc       <= '0;
      rom_ad    <= '0;
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_val   <= '0;
      done      <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      if (state == IDLE && start) begin
        pix_reg <= pix;
        rom_ad  <= BASE_AD;
        i_cnt   <= '0;
        k_cnt   <= '0;
      end else if (state == STREAM) begin
        rd_valid <= 1'b1;
        rd_i     <= i_cnt;
        rd_k     <= k_cnt;
        if (!last_addr) rom_ad <= rom_ad + 8'd1;
        if (i_cnt == LAST_I) begin
          i_cnt <= '0;
          k_cnt <= k_cnt + IDX_W'(1);
        end else begin
          i_cnt <= i_cnt + I_W'(1);
        end
      end
      if (rd_valid) begin
        if (rd_i == LAST_I) begin
          acc       <= '0;
          out_val   <= res_out;
          out_idx   <= rd_k;
          out_valid <= 1'b1;
          done      <= (rd_k == LAST_K);
        end else if (pix_bit) begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_l1_neuron_mac.sv
// Randomised self-checking bench for l1_neuron_mac against a ROM model and an
// arithmetic reference; honours L1_NEURON_RELU_EN when defined.
module tb_l1_neuron_mac;
  localparam int N_IN      = 36;
  localparam int N_OUT     = 4;
  localparam int ACC_W     = 24;
  localparam int BASE_ADDR = 0;
  localparam int TOT       = N_OUT * (N_IN + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [N_IN-1:0]  pix = '0;
  logic             busy, rom_ce, rom_oce;
  logic [7:0]       rom_ad;
  logic [15:0]      rom_dout = '0;
  logic             out_valid;
  logic [1:0]       out_idx;
  logic [ACC_W-1:0] out_val;
  logic             done;

  logic [15:0]      rom_mem [256];
  logic [ACC_W-1:0] held_val = '0;
  logic [1:0]       held_idx = '0;
  int checks = 0;
  int errors = 0;

  l1_neuron_mac #(.N_IN(N_IN), .N_OUT(N_OUT), .ACC_W(ACC_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix(pix), .busy(busy),
    .rom_ce(rom_ce), .rom_oce(rom_oce), .rom_ad(rom_ad), .rom_dout(rom_dout),
    .out_valid(out_valid), .out_idx(out_idx), .out_val(out_val), .done(done)
  );

  always #5 clk = ~clk;

  // Bypass-mode pROM: one-cycle registered read while enabled.
  always @(posedge clk) if (rom_ce) rom_dout <= rom_mem[rom_ad];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // mode 0: w=1,b=16; 1: w=-1,b=0; 2: w=i+1,b=0; 3: random.
  task automatic loadRom(input int mode);
    for (int j = 0; j < 256; j++) rom_mem[j] = 16'h0;
    for (int j = 0; j < TOT; j++) begin
      int i;
      i = j % (N_IN + 1);
      case (mode)
        0:       rom_mem[BASE_ADDR+j] = (i == N_IN) ? 16'h0010 : 16'h0001;
        1:       rom_mem[BASE_ADDR+j] = (i == N_IN) ? 16'h0000 : 16'hFFFF;
        2:       rom_mem[BASE_ADDR+j] = (i == N_IN) ? 16'h0000 : 16'(i + 1);
        default: rom_mem[BASE_ADDR+j] = 16'($urandom);
      endcase
    end
  endtask

  function automatic logic [ACC_W-1:0] refNeuron(input int k, input logic [N_IN-1:0] p);
    longint sum;
    int base;
    base = BASE_ADDR + k * (N_IN + 1);
    sum = 0;
    for (int i = 0; i < N_IN; i++)
      if (p[i]) sum += longint'($signed(rom_mem[base+i]));
    sum += longint'($signed(rom_mem[base+N_IN]));
`ifdef L1_NEURON_RELU_EN
    if (sum < 0) sum = 0;
`endif
    return ACC_W'(sum);
  endfunction

  // Called at a negedge; drives start there. mode 0: plain, 1: extra start
  // pulses at T+10 and T+150, 2: rst_n low during T+50.
  task automatic applyStimulus(input logic [N_IN-1:0] p, input int mode);
    logic [ACC_W-1:0] expv [N_OUT];
    int last_n;
    for (int k = 0; k < N_OUT; k++) expv[k] = refNeuron(k, p);
    last_n = (mode == 2) ? 160 : TOT + 3;
    start = 1'b1;
    pix   = p;
    for (int n = 1; n <= last_n; n++) begin
      bit strobe, aborted;
      int k;
      @(negedge clk);
      start = (mode == 1) && (n == 10 || n == TOT + 2);
      if (mode == 1 && n == 10) pix = ~p;
      if (mode == 2) rst_n = (n != 50);
      aborted = (mode == 2) && (n >= 51);
      k = (n - N_IN - 3) / (N_IN + 1);
      strobe = !aborted && (n >= N_IN + 3) && (n <= TOT + 2) && ((n - N_IN - 3) % (N_IN + 1) == 0);
      if (aborted && n == 51) begin
        held_val = '0;
        held_idx = '0;
      end
      if (strobe) begin
        held_val = expv[k];
        held_idx = 2'(k);
      end
      checkOutput("busy", busy, !aborted && n <= TOT + 2);
      checkOutput("rom_ce", rom_ce, !aborted && n <= TOT);
      if (aborted) checkOutput("rom_ad_rst", rom_ad, 0);
      else if (n <= TOT) checkOutput("rom_ad", rom_ad, BASE_ADDR + n - 1);
      checkOutput("out_valid", out_valid, strobe);
      checkOutput("done", done, strobe && k == N_OUT - 1);
      checkOutput("out_val", out_val, held_val);
      checkOutput("out_idx", out_idx, held_idx);
      checkOutput("rom_oce", rom_oce, 1);
    end
  endtask

  initial begin
    logic [63:0] r;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_rom_ce", rom_ce, 0);
    checkOutput("rst_rom_ad", rom_ad, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_idx", out_idx, 0);
    checkOutput("rst_out_val", out_val, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rom_oce", rom_oce, 1);
    rst_n = 1'b1;
    @(negedge clk);

    loadRom(0);
    applyStimulus({N_IN{1'b1}}, 0);
    applyStimulus('0, 0);
    loadRom(1);
    applyStimulus({N_IN{1'b1}}, 0);
    loadRom(2);
    applyStimulus(36'h000000005, 0);
    loadRom(3);
    r = {$urandom, $urandom};
    applyStimulus(r[N_IN-1:0], 1);
    r = {$urandom, $urandom};
    applyStimulus(r[N_IN-1:0], 2);
    r = {$urandom, $urandom};
    applyStimulus(r[N_IN-1:0], 0);
    for (int t = 0; t < 4; t++) begin
      loadRom(3);
      r = {$urandom, $urandom};
      applyStimulus(r[N_IN-1:0], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
